// File: rtl/cp0_trap_ctrl_pkg.sv
// Shared CPU constants for the CP0 trap path: cause codes, next-PC select
// encodings, CP0 register indices, and a helper that maps the prioritised
// trap decode onto the cause code written into CP0.
package cp0_trap_ctrl_pkg;

    localparam logic [4:0] CAUSE_NONE    = 5'b00000;
    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_VEC = 2'b01;
    localparam logic [1:0] PCSEL_EPC = 2'b10;

    localparam logic [4:0] CP0_STATUS_IDX = 5'd12;
    localparam logic [4:0] CP0_CAUSE_IDX  = 5'd13;
    localparam logic [4:0] CP0_EPC_IDX    = 5'd14;

    typedef enum logic [1:0] {
        CNT_SYSCALL = 2'd0,
        CNT_BREAK   = 2'd1,
        CNT_TEQ     = 2'd2,
        CNT_ERET    = 2'd3
    } cnt_sel_e;

    // Inputs are already prioritised, so at most one is high.
    function automatic logic [4:0] trap_cause(input logic sys, input logic brk,
                                              input logic teq);
        logic [4:0] c;
        c = CAUSE_NONE;
        if (sys)      c = CAUSE_SYSCALL;
        else if (brk) c = CAUSE_BREAK;
        else if (teq) c = CAUSE_TEQ;
        return c;
    endfunction

endpackage

// File: rtl/cp0_trap_ctrl_sat_counter.sv
// trap_sat_counter: per-cause debug counter, increments on inc unless hold,
// sticks at all-ones. Ports: clk, cp0_rst (async, active-high), inc, hold,
// cnt (registered count, updates on the rising edge).
module trap_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             cp0_rst,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge cp0_rst) begin
        if (cp0_rst) begin
            cnt_q <= '0;
        end else if (inc && !hold && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cp0_trap_ctrl.sv
// cp0_trap_ctrl: decodes SYSCALL/BREAK/TEQ/ERET into the CP0 cause code and
// next-PC select, tracks exception nesting depth, latches lockup on nesting
// overflow and eret_err on an unmatched ERET, and keeps per-cause counters.
// Ports: clk, cp0_rst, ena, decode + rs/rt in; cause/exc_take/eret_take/
// pc_sel/vector combinational out; depth/lockup/eret_err registered; cnt_sel
// selects the counter shown combinationally on cnt_out.
module cp0_trap_ctrl
    import cp0_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = 32'h0040_0004,
    parameter int          MAX_DEPTH   = 6,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             cp0_rst,
    input  logic             ena,
    input  logic             is_syscall,
    input  logic             is_break,
    input  logic             is_teq,
    input  logic             is_eret,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic [4:0]       cause,
    output logic             exc_take,
    output logic             eret_take,
    output logic [1:0]       pc_sel,
    output logic [31:0]      vector,
    output logic [2:0]       depth,
    output logic             lockup,
    output logic             eret_err,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    localparam logic [2:0] MAX_D = 3'(MAX_DEPTH);

    logic [2:0] depth_q;
    logic       lockup_q;
    logic       eret_err_q;

    // Priority ERET > SYSCALL > BREAK > TEQ; TEQ only counts as a trap when
    // the operands match, otherwise it is an ordinary instruction.
    logic sel_eret, sel_sys, sel_brk, sel_teq, trap_req, active, overflow;

    assign sel_eret = is_eret;
    assign sel_sys  = !is_eret && is_syscall;
    assign sel_brk  = !is_eret && !is_syscall && is_break;
    assign sel_teq  = !is_eret && !is_syscall && !is_break && is_teq
                      && (rs_val == rt_val);
    assign trap_req = sel_sys || sel_brk || sel_teq;

    // Lockup freezes everything until reset, exactly like ena low.
    assign active    = ena && !lockup_q;
    assign exc_take  = active && trap_req && (depth_q < MAX_D);
    assign overflow  = active && trap_req && (depth_q >= MAX_D);
    assign eret_take = active && sel_eret;

    // Overflowing traps leave cause at NONE so CP0 is not written.
    assign cause  = exc_take ? trap_cause(sel_sys, sel_brk, sel_teq) : CAUSE_NONE;
    assign pc_sel = exc_take  ? PCSEL_VEC :
                    eret_take ? PCSEL_EPC : PCSEL_SEQ;
    assign vector = VECTOR_ADDR;

    always_ff @(posedge clk or posedge cp0_rst) begin
        if (cp0_rst) begin
            depth_q    <= '0;
            lockup_q   <= 1'b0;
            eret_err_q <= 1'b0;
        end else begin
            if (exc_take) begin
                depth_q <= depth_q + 3'd1;
            end else if (eret_take && (depth_q != 3'd0)) begin
                depth_q <= depth_q - 3'd1;
            end
            if (overflow) begin
                lockup_q <= 1'b1;
            end
            // Unmatched ERET still returns to EPC but is flagged.
            if (eret_take && (depth_q == 3'd0)) begin
                eret_err_q <= 1'b1;
            end
        end
    end

    assign depth    = depth_q;
    assign lockup   = lockup_q;
    assign eret_err = eret_err_q;

    logic             cnt_hold;
    logic [CNT_W-1:0] cnt_sys, cnt_brk, cnt_teq, cnt_eret;

    assign cnt_hold = lockup_q || !ena;

    trap_sat_counter #(.CNT_W(CNT_W)) u_cnt_sys (
        .clk(clk), .cp0_rst(cp0_rst), .inc(exc_take && sel_sys),
        .hold(cnt_hold), .cnt(cnt_sys)
    );
    trap_sat_counter #(.CNT_W(CNT_W)) u_cnt_brk (
        .clk(clk), .cp0_rst(cp0_rst), .inc(exc_take && sel_brk),
        .hold(cnt_hold), .cnt(cnt_brk)
    );
    trap_sat_counter #(.CNT_W(CNT_W)) u_cnt_teq (
        .clk(clk), .cp0_rst(cp0_rst), .inc(exc_take && sel_teq),
        .hold(cnt_hold), .cnt(cnt_teq)
    );
    // Every taken ERET counts, including the unmatched ones.
    trap_sat_counter #(.CNT_W(CNT_W)) u_cnt_eret (
        .clk(clk), .cp0_rst(cp0_rst), .inc(eret_take),
        .hold(cnt_hold), .cnt(cnt_eret)
    );

    always_comb begin
        cnt_out = '0;
        case (cnt_sel_e'(cnt_sel))
            CNT_SYSCALL: cnt_out = cnt_sys;
            CNT_BREAK:   cnt_out = cnt_brk;
            CNT_TEQ:     cnt_out = cnt_teq;
            CNT_ERET:    cnt_out = cnt_eret;
            default:     cnt_out = '0;
        endcase
    end

endmodule

// File: doc/cp0_trap_ctrl.md
# cp0_trap_ctrl

Trap controller that sits directly upstream of the CP0 register block in the single-cycle CPU. It decodes the current instruction's trap class (SYSCALL, BREAK, TEQ, ERET) into the 5-bit cause code CP0 latches. It drives the next-PC select that consumes CP0's EPC output. It tracks exception nesting depth against the STATUS shift-by-5 scheme, locks the core on nesting overflow, and keeps per-cause saturating trap counters for debug.

## Interface
- VECTOR_ADDR, 32'h0040_0004: exception handler entry address.
- MAX_DEPTH, 6: maximum nesting levels; one per 5-bit STATUS shift.
- CNT_W, 16: width of each trap counter.

- clk  in  1  CPU clock; state updates on rising edge.
- cp0_rst  in  1  reset, asynchronous, active-high.
- ena  in  1  CPU enable; when low, nothing is taken or counted.
- is_syscall  in  1  decoded SYSCALL.
- is_break  in  1  decoded BREAK.
- is_teq  in  1  decoded TEQ.
- is_eret  in  1  decoded ERET.
- rs_val  in  32  GPR rs value, used for the TEQ compare.
- rt_val  in  32  GPR rt value, used for the TEQ compare.
- cause  out  5  to CP0: 01000 SYSCALL, 01001 BREAK, 01101 TEQ taken, 00000 otherwise.
- exc_take  out  1  trap taken this cycle.
- eret_take  out  1  return taken this cycle.
- pc_sel  out  2  00 sequential/branch, 01 VECTOR_ADDR, 10 EPC from CP0.
- vector  out  32  constant VECTOR_ADDR.
- depth  out  3  current nesting depth.
- lockup  out  1  sticky; core must hold PC while high.
- eret_err  out  1  sticky; ERET executed at depth 0.
- cnt_sel  in  2  counter read select: 0 SYSCALL, 1 BREAK, 2 TEQ, 3 ERET.
- cnt_out  out  CNT_W  selected counter value, combinational.

## Operation
- The decode inputs are one-hot by construction. If more than one is high, priority is ERET > SYSCALL > BREAK > TEQ.
- TEQ is taken only if rs_val == rt_val (full 32-bit compare). An untaken TEQ behaves as a normal instruction: cause 00000, pc_sel 00, no count.
- A trap is taken when ena is high, lockup is low, and depth < MAX_DEPTH. Effects:
  - exc_take=1, pc_sel=01, cause driven.
  - depth increments at the next clk edge.
  - The matching counter increments, saturating at all-ones.
- A trap decoded while depth == MAX_DEPTH causes overflow:
  - lockup is set at the next edge; cause is 00000, so CP0 is not written.
  - pc_sel=00; depth is unchanged.
- ERET with depth > 0: eret_take=1, pc_sel=10, depth decrements, ERET counter increments.
- ERET with depth == 0:
  - eret_take=1 and pc_sel=10, so CP0 still returns to its EPC.
  - depth stays 0 and eret_err is set.
- While lockup is high, all outputs are forced inactive: cause 00000, exc_take/eret_take 0, pc_sel 00. State is frozen, counters included. Only cp0_rst clears it.
- While ena is low, outputs are inactive and state holds.

## Timing
- cause, exc_take, eret_take and pc_sel are combinational from the current-cycle inputs and registered state. They are stable for the whole cycle, so CP0 samples them on its falling edge.
- depth, the counters, lockup and eret_err update on the rising edge that ends the trapping cycle.
- Trap-to-vector latency is 0 cycles: the PC is loaded with VECTOR_ADDR at that same edge.
- Reset values: depth 0, all counters 0, lockup 0, eret_err 0. All outputs are inactive (pc_sel 00, cause 00000). vector is always VECTOR_ADDR.
- If cp0_rst asserts mid-cycle, state clears immediately. A trap in that cycle is lost; its depth increment and count are not recorded.

## Structure
- The shared CPU package holds:
  - cause code constants CAUSE_SYSCALL, CAUSE_BREAK, CAUSE_TEQ, CAUSE_NONE;
  - pc_sel encodings PCSEL_SEQ, PCSEL_VEC, PCSEL_EPC;
  - the STATUS/CAUSE/EPC register index constants 12/13/14.
- Sub-module trap_sat_counter (parameter CNT_W; inputs inc and hold; async reset) is instantiated four times.

## Test plan
- After reset: depth=0, lockup=0, cnt_out=0 for every cnt_sel, pc_sel=00, cause=00000.
- is_syscall=1, ena=1 -> cause=01000, pc_sel=01, exc_take=1. After the edge: depth=1 and SYSCALL counter=1.
- is_teq with rs=rt=32'h1234 -> cause=01101, pc_sel=01. With rs=1, rt=2 -> cause=00000, pc_sel=00, TEQ counter unchanged.
- Six BREAKs then a seventh -> depth=6. The seventh gives cause=00000 and lockup=1 after the edge. A following SYSCALL is ignored until cp0_rst.
- ERET at depth 0 -> pc_sel=10, eret_err=1, depth=0. SYSCALL then ERET -> depth 1 then 0, ERET counter=2.
- Force the BREAK counter to 16'hFFFE via CNT_W=16, then three BREAK/ERET pairs -> counter holds at 16'hFFFF. Assert cp0_rst mid-cycle during a trap -> all state is 0 immediately.
